bloom_bucket_ctrl: RTL and testbench
====================================

// Module: bloom_bucket_ctrl
// PURPOSE
//  Sequences bucket rotation of the time-decaying bloom filter. On each watchdog update pulse it selects
//  the oldest bucket, sweeps (zeroes) every word of it through the shared memory write port, then makes
//  it the current insert bucket. Arbitrates that port between the packet datapath and the clear sweep,
//  with bounded datapath priority so the sweep cannot starve. Sits between watchdog and bloom memory.
// PARAMETERS
//  NUM_BUCKETS   4   number of buckets in the filter (>=2); BUCKET_BITS = log2(NUM_BUCKETS)
//  ADDR_WIDTH    10  word address width; each bucket holds 2**ADDR_WIDTH words
//  STARVE_LIMIT  8   max consecutive datapath grants during a sweep before one clear write is forced
// PORTS
//  clk         in   1            clock
//  reset       in   1            synchronous, active-high reset
//  update      in   1            1-cycle rotate request from watchdog
//  enable      in   1            0 = sweep paused, updates ignored
//  dp_req      in   1            datapath requests the shared memory port this cycle
//  dp_ack      out  1            datapath granted the port this cycle (combinational)
//  clr_wr      out  1            clear write strobe: write zero at clr_addr in bucket clr_bucket
//  clr_addr    out  ADDR_WIDTH   word address of current clear write
//  clr_bucket  out  BUCKET_BITS  bucket being swept
//  cur_bucket  out  BUCKET_BITS  bucket receiving inserts
//  busy        out  1            sweep/rotate in progress
//  overrun     out  1            1-cycle pulse: update arrived while busy (dropped)
// BEHAVIOUR
//  - Reset: state IDLE; cur_bucket=0, clr_bucket=0, clr_addr=0, starve_cnt=0; busy=0, overrun=0,
//    clr_wr=0, dp_ack=0. Reset mid-sweep abandons the sweep; no partial-rotation state survives.
//  - FSM IDLE -> SWEEP -> ROTATE -> IDLE.
//  - IDLE: dp_ack=dp_req, clr_wr=0. update=1 & enable=1 at edge N: clr_bucket<=(cur_bucket+1) mod
//    NUM_BUCKETS (wrap NUM_BUCKETS-1 -> 0), clr_addr<=0, starve_cnt<=0, SWEEP; busy=1 from N+1.
//    update with enable=0 ignored, no overrun.
//  - SWEEP, enable=1: if dp_req & starve_cnt<STARVE_LIMIT: dp_ack=1, clr_wr=0, starve_cnt++.
//    Else clr_wr=1, dp_ack=0, starve_cnt<=0, clr_addr++. dp_ack and clr_wr never both 1.
//  - SWEEP, enable=0: clr_wr=0, dp_ack=dp_req, clr_addr/starve_cnt hold.
//  - Clear write at clr_addr=2**ADDR_WIDTH-1 -> ROTATE (clr_addr wraps to 0). Min sweep 2**ADDR_WIDTH cycles.
//  - ROTATE (1 cycle): cur_bucket<=clr_bucket, dp_ack=dp_req, clr_wr=0; next IDLE, busy=0.
//  - update=1 while busy (SWEEP or ROTATE): dropped, overrun=1 next cycle; sweep unaffected.
//  - cur_bucket never equals clr_bucket while busy; new inserts land in fresh bucket only after ROTATE.
//  - starve_cnt width log2(STARVE_LIMIT+1); saturates nowhere since it is reset on every clear write.
// CONFIGURATION
//  BLOOM_CTRL_STATS_EN defined: adds outputs rotate_count[31:0] (++ on each ROTATE, wraps) and
//   overrun_count[15:0] (++ per overrun pulse, saturates at 16'hFFFF); both cleared by reset.
//  Not defined: those ports and counters are absent; all other behaviour identical.
// TESTING (ADDR_WIDTH=3, NUM_BUCKETS=4, STARVE_LIMIT=2 unless stated)
//  1. reset, enable=1, dp_req=0, update pulse -> busy next cycle, clr_bucket=1, clr_wr on addrs 0..7
//     in 8 consecutive cycles, then ROTATE; cur_bucket=1, busy=0 after 10 cycles total.
//  2. dp_req held 1 through sweep -> pattern ack,ack,clr repeating; 8 clears in 24 cycles; never
//     dp_ack&clr_wr.
//  3. four update pulses spaced 20 cycles -> cur_bucket 1,2,3,0 (wrap checked).
//  4. second update 3 cycles into a sweep -> overrun=1 exactly one cycle, sweep completes normally,
//     cur_bucket advances by 1 only.
//  5. enable dropped for 5 cycles at clr_addr=4 -> no clr_wr, clr_addr holds 4, dp_ack=dp_req;
//     resumes at 4 on enable=1.
//  6. reset asserted at clr_addr=5 -> next cycle busy=0, cur_bucket=0, clr_addr=0; with
//     BLOOM_CTRL_STATS_EN, counters read 0.

Source files
------------

// File: rtl/bloom_bucket_ctrl.sv
// Bucket-rotation sequencer for the time-decaying bloom filter: sweeps the oldest bucket to zero
// through the shared write port, then promotes it to insert bucket. Optional BLOOM_CTRL_STATS_EN adds counters.
module bloom_bucket_ctrl #(
    parameter int unsigned NUM_BUCKETS  = 4,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned BUCKET_BITS = (NUM_BUCKETS > 1) ? $clog2(NUM_BUCKETS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   update,
    input  logic                   enable,
    input  logic                   dp_req,
    output logic                   dp_ack,
    output logic                   clr_wr,
    output logic [ADDR_WIDTH-1:0]  clr_addr,
    output logic [BUCKET_BITS-1:0] clr_bucket,
    output logic [BUCKET_BITS-1:0] cur_bucket,
    output logic                   busy,
    output logic                   overrun
`ifdef BLOOM_CTRL_STATS_EN
    ,
    output logic [31:0]            rotate_count,
    output logic [15:0]            overrun_count
`endif
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR   = '1;
    localparam logic [BUCKET_BITS-1:0] LAST_BUCKET = BUCKET_BITS'(NUM_BUCKETS - 1);
    localparam logic [CNT_W-1:0]       STARVE_MAX  = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_ROTATE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_addr_q, clr_addr_d;
    logic [BUCKET_BITS-1:0] clr_bucket_q, clr_bucket_d;
    logic [BUCKET_BITS-1:0] cur_bucket_q, cur_bucket_d;
    logic [CNT_W-1:0]       starve_q, starve_d;
    logic                   busy_q, overrun_q, overrun_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            clr_addr_q   <= '0;
            clr_bucket_q <= '0;
            cur_bucket_q <= '0;
            starve_q     <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            clr_bucket_q <= clr_bucket_d;
            cur_bucket_q <= cur_bucket_d;
            starve_q     <= starve_d;
            busy_q       <= (state_d != S_IDLE);
            overrun_q    <= overrun_d;
        end
    end

    // Next-state and port arbitration; the datapath wins unless it has hogged STARVE_LIMIT grants
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        clr_bucket_d = clr_bucket_q;
        cur_bucket_d = cur_bucket_q;
        starve_d     = starve_q;
        dp_ack       = 1'b0;
        clr_wr       = 1'b0;
        overrun_d    = update && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                dp_ack = dp_req;
                if (update && enable) begin
                    clr_bucket_d = (cur_bucket_q == LAST_BUCKET) ? '0
                                                                 : cur_bucket_q + BUCKET_BITS'(1);
                    clr_addr_d   = '0;
                    starve_d     = '0;
                    state_d      = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (!enable) begin
                    dp_ack = dp_req;
                end else if (dp_req && (starve_q < STARVE_MAX)) begin
                    dp_ack   = 1'b1;
                    starve_d = starve_q + CNT_W'(1);
                end else begin
                    clr_wr     = 1'b1;
                    starve_d   = '0;
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d = S_ROTATE;
                    end
                end
            end
            S_ROTATE: begin
                dp_ack       = dp_req;
                cur_bucket_d = clr_bucket_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign clr_addr   = clr_addr_q;
    assign clr_bucket = clr_bucket_q;
    assign cur_bucket = cur_bucket_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

`ifdef BLOOM_CTRL_STATS_EN
    logic [31:0] rotate_cnt_q;
    logic [15:0] overrun_cnt_q;

    // Rotation count wraps; overrun count sticks at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            rotate_cnt_q  <= '0;
            overrun_cnt_q <= '0;
        end else begin
            if (state_q == S_ROTATE) begin
                rotate_cnt_q <= rotate_cnt_q + 32'd1;
            end
            if (overrun_d && (overrun_cnt_q != 16'hFFFF)) begin
                overrun_cnt_q <= overrun_cnt_q + 16'd1;
            end
        end
    end

    assign rotate_count  = rotate_cnt_q;
    assign overrun_count = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_bloom_bucket_ctrl.sv
// Scoreboard bench for bloom_bucket_ctrl: expected clear writes are queued at each update and
// checked by a negedge monitor; status outputs are checked against hand-computed values.
module tb_bloom_bucket_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned AW = 3;
    localparam int unsigned SL = 2;
    localparam int unsigned BB = 2;

    logic          clk = 1'b0;
    logic          reset, update, enable, dp_req;
    logic          dp_ack, clr_wr, busy, overrun;
    logic [AW-1:0] clr_addr;
    logic [BB-1:0] clr_bucket, cur_bucket;
`ifdef BLOOM_CTRL_STATS_EN
    logic [31:0]   rotate_count;
    logic [15:0]   overrun_count;
`endif

    bloom_bucket_ctrl #(
        .NUM_BUCKETS (NB),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .update       (update),
        .enable       (enable),
        .dp_req       (dp_req),
        .dp_ack       (dp_ack),
        .clr_wr       (clr_wr),
        .clr_addr     (clr_addr),
        .clr_bucket   (clr_bucket),
        .cur_bucket   (cur_bucket),
        .busy         (busy),
        .overrun      (overrun)
`ifdef BLOOM_CTRL_STATS_EN
        ,
        .rotate_count (rotate_count),
        .overrun_count(overrun_count)
`endif
    );

    always #5 clk = ~clk;

    int              n_tests = 0;
    int              n_fail  = 0;
    int              clr_seen = 0;
    bit              mon_en = 1'b0;
    logic [BB+AW-1:0] exp_clr[$];
    int              model_cur = 0;
    int              model_next = 0;
    bit              model_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one update pulse; queue the sweep it should produce if the controller is idle
    task automatic do_update();
        update = 1'b1;
        if (!model_busy && enable) begin
            model_next = (model_cur + 1) % NB;
            for (int a = 0; a < (1 << AW); a++) begin
                exp_clr.push_back({BB'(model_next), AW'(a)});
            end
            model_busy = 1'b1;
        end
        step();
        update = 1'b0;
    endtask

    task automatic end_sweep();
        model_busy = 1'b0;
        model_cur  = model_next;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        chk(name, 32'(k < 200), 32'd1);
        end_sweep();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_clr.delete();
        model_busy = 1'b0;
        model_cur  = 0;
    endtask

    // Monitor: every clear write must match the head of the expected queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (clr_wr === 1'b1) begin
                clr_seen++;
                if (exp_clr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL clr_unexpected: got bucket %0d addr %0d expected none",
                             clr_bucket, clr_addr);
                end else begin
                    chk("clr_write", 32'({clr_bucket, clr_addr}), 32'(exp_clr.pop_front()));
                end
            end
            chk("ack_clr_exclusive", 32'(dp_ack & clr_wr), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int exp_cur[4];
        exp_cur = '{1, 2, 3, 0};
        reset = 1'b1; update = 1'b0; enable = 1'b1; dp_req = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        mon_en = 1'b1;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur", 32'(cur_bucket), 32'd0);
        chk("rst_clr_bucket", 32'(clr_bucket), 32'd0);
        chk("rst_clr_addr", 32'(clr_addr), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_clr_wr", 32'(clr_wr), 32'd0);
        dp_req = 1'b1;
        #1 chk("idle_ack_follows", 32'(dp_ack), 32'd1);
        dp_req = 1'b0;
        #1 chk("idle_ack_low", 32'(dp_ack), 32'd0);

        // 1: uncontended sweep, 8 back-to-back clears then rotate
        s = clr_seen;
        do_update();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_clr_bucket", 32'(clr_bucket), 32'd1);
        repeat (8) step();
        chk("t1_clears", 32'(clr_seen - s), 32'd8);
        chk("t1_rotate_busy", 32'(busy), 32'd1);
        chk("t1_cur_before", 32'(cur_bucket), 32'd0);
        step();
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_cur", 32'(cur_bucket), 32'd1);
        end_sweep();

        // 2: datapath held requesting -> ack,ack,clr pattern
        dp_req = 1'b1;
        do_update();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk("t2_ack", 32'(dp_ack), 32'((i % 3) != 2));
            chk("t2_clr", 32'(clr_wr), 32'((i % 3) == 2));
            @(posedge clk);
            #1;
        end
        chk("t2_rotate_busy", 32'(busy), 32'd1);
        chk("t2_rotate_ack", 32'(dp_ack), 32'd1);
        step();
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_cur", 32'(cur_bucket), 32'd2);
        dp_req = 1'b0;
        end_sweep();

        // update while disabled is ignored silently
        enable = 1'b0;
        update = 1'b1;
        step();
        update = 1'b0;
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_overrun", 32'(overrun), 32'd0);
        enable = 1'b1;

        // 3: four rotations from reset wrap the bucket index
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_update();
            repeat (19) step();
            chk("t3_busy", 32'(busy), 32'd0);
            chk("t3_cur", 32'(cur_bucket), 32'(exp_cur[k]));
            end_sweep();
        end

        // 4: update during a sweep -> single overrun pulse, one advance only
        do_update();
        repeat (2) step();
        do_update();
        chk("t4_overrun_hi", 32'(overrun), 32'd1);
        step();
        chk("t4_overrun_lo", 32'(overrun), 32'd0);
        chk("t4_still_busy", 32'(busy), 32'd1);
        wait_idle("t4_done");
        chk("t4_cur", 32'(cur_bucket), 32'd1);

        // 5: pause at address 4 for 5 cycles
        do_update();
        repeat (4) step();
        chk("t5_addr", 32'(clr_addr), 32'd4);
        enable = 1'b0;
        dp_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_clr", 32'(clr_wr), 32'd0);
            chk("t5_ack", 32'(dp_ack), 32'd1);
            chk("t5_hold", 32'(clr_addr), 32'd4);
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        dp_req = 1'b0;
        @(negedge clk);
        chk("t5_resume_clr", 32'(clr_wr), 32'd1);
        chk("t5_resume_addr", 32'(clr_addr), 32'd4);
        @(posedge clk);
        #1;
        wait_idle("t5_done");
        chk("t5_cur", 32'(cur_bucket), 32'd2);

        // 6: reset in the middle of a sweep
        do_update();
        repeat (5) step();
        chk("t6_addr", 32'(clr_addr), 32'd5);
`ifdef BLOOM_CTRL_STATS_EN
        chk("t6_rot_cnt_pre", rotate_count, 32'd6);
        chk("t6_ovr_cnt_pre", 32'(overrun_count), 32'd1);
`endif
        do_reset();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cur", 32'(cur_bucket), 32'd0);
        chk("t6_clr_addr", 32'(clr_addr), 32'd0);
        chk("t6_clr_bucket", 32'(clr_bucket), 32'd0);
`ifdef BLOOM_CTRL_STATS_EN
        chk("t6_rot_cnt", rotate_count, 32'd0);
        chk("t6_ovr_cnt", 32'(overrun_count), 32'd0);
`endif
        repeat (3) step();
        chk("t6_no_clr_after_reset", 32'(clr_wr), 32'd0);
        chk("queue_drained", 32'(exp_clr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
